multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle sequencer for the RV32I core. It replaces the single-cycle opcode decoder with an FSM that reuses one ALU and one unified memory port across cycles. It drives the PC/IR/MDR/ALUOut-style datapath enables and muxes, and waits on a variable-latency memory ready handshake. A watchdog traps a hung memory.

Parameters:
MEM_TIMEOUT, 16, max consecutive cycles mem_ready may stay low in FETCH or MEM before a bus error (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
opcode  in  7  IR[6:0]; stable from DECODE through WB
mem_ready  in  1  memory completes current access this cycle
branch_taken  in  1  datapath comparator result, valid in EXEC for BR
pc_write  out  1  load PC
ir_write  out  1  load IR (and old_pc <= PC)
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write
alu_src_a  out  2  00 PC, 01 rs1, 10 old_pc, 11 zero
alu_src_b  out  2  00 rs2, 01 const 4, 10 imm
alu_op  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
pc_src  out  2  00 ALU result, 01 ALUOut
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 old_pc+4
state  out  3  current state encoding (debug)
instr_retired  out  1  one-cycle pulse on final cycle of each instruction
bus_error  out  1  sticky; memory timeout occurred
illegal_instr  out  1  sticky; unsupported opcode decoded
halted  out  1  FSM in TRAP

Behaviour:
- Opcodes: R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111; anything else is illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Register state, wait counter, and sticky flags. Outputs are combinational from the state, plus opcode/mem_ready/branch_taken where noted.
- Any output not listed below is 0 in that state.
- Reset (async):
  - state=FETCH, counter=0, bus_error=illegal_instr=0.
  - While reset is high, force every strobe to 0: pc_write, ir_write, mem_read, mem_write, reg_write, instr_retired.
- FETCH:
  - mem_read=1, iord=0, a=00, b=01, alu_op=00.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
  - Otherwise stay and increment the counter.
- DECODE:
  - a=10, b=10, alu_op=00; datapath latches the branch/JAL target in ALUOut.
  - Illegal opcode: set illegal_instr, go to TRAP. Otherwise go to EXEC.
- EXEC, by opcode:
  - R: a=01, b=00, op=10, go to WB.
  - I: a=01, b=10, op=11, go to WB.
  - LW/SW: a=01, b=10, op=00, go to MEM.
  - LUI: a=11, b=10, go to WB.
  - AUIPC: a=10, b=10, go to WB.
  - BR: a=01, b=00, op=01; pc_write=branch_taken, pc_src=01; instr_retired=1; go to FETCH.
  - JAL: pc_write=1, pc_src=01, go to WB.
  - JALR: a=01, b=10, op=00, pc_write=1, pc_src=00 (datapath clears bit 0), go to WB.
- MEM:
  - iord=1; mem_read=1 for LW, mem_write=1 for SW; hold these until mem_ready.
  - On mem_ready: LW goes to WB; SW pulses instr_retired and goes to FETCH.
  - Otherwise stay and increment the counter.
- WB:
  - reg_write=1, instr_retired=1, go to FETCH.
  - mem_to_reg: 01 for LW, 10 for JAL/JALR, 00 otherwise.
- Watchdog:
  - Counter is $clog2(MEM_TIMEOUT+1) bits and clears on every state change.
  - In FETCH/MEM with mem_ready low and counter == MEM_TIMEOUT-1: set bus_error, go to TRAP.
  - mem_ready high on that same cycle wins: no error.
- TRAP: all strobes 0, halted=1; remain until reset.
- Latency with zero memory wait:
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - BR: 3 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each memory wait cycle adds 1.
- Reset asserted mid-instruction aborts it: no reg_write or mem_write pulse is emitted, and the FSM restarts at FETCH.

Test Plan:
- R-type add, mem_ready=1 always -> state 0,1,2,4,0; reg_write high only in cycle 4; instr_retired pulses once; pc_write high in FETCH only.
- LW, mem_ready low 3 cycles in MEM -> mem_read/iord held 4 cycles, then WB with mem_to_reg=01; total 8 cycles.
- BR with branch_taken=1, then 0 -> pc_write=1 with pc_src=01 in EXEC in the first case, pc_write=0 in the second; both return to FETCH after 3 cycles.
- opcode=7'b1111111 -> TRAP after DECODE; illegal_instr=1, halted=1, no strobes thereafter.
- MEM_TIMEOUT=4, mem_ready stuck low in FETCH -> TRAP on the 4th cycle, bus_error=1. A separate run with mem_ready rising on that 4th cycle must produce no error.
- SW with reset asserted during MEM wait -> mem_write drops immediately, state=0, flags clear; the next fetch proceeds normally.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32I core. One ALU and one unified memory
// port are shared across FETCH/DECODE/EXEC/MEM/WB. Memory accesses wait on
// a ready handshake, and a watchdog traps a memory that never answers.
// Control outputs are combinational from the current state. Some of them
// also depend on opcode, mem_ready or branch_taken.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [1:0] mem_to_reg,
    output logic [2:0] state,
    output logic       instr_retired,
    output logic       bus_error,
    output logic       illegal_instr,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_error_q, bus_error_d;
    logic          illegal_q, illegal_d;
    logic          opcode_legal;

    // Classify the opcode held in IR as a supported RV32I instruction or not.
    always_comb begin
        unique case (opcode)
            OP_R, OP_I, OP_LW, OP_SW, OP_BR,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_legal = 1'b1;
            default:                          opcode_legal = 1'b0;
        endcase
    end

    // Next state, watchdog counter and sticky error flags.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_error_d = bus_error_q;
        illegal_d   = illegal_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (cnt_q == WAIT_LAST) begin
                    bus_error_d = 1'b1;
                    state_d     = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (opcode_legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_EXEC: begin
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEM;
                end else if (opcode == OP_BR) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
                end else if (cnt_q == WAIT_LAST) begin
                    bus_error_d = 1'b1;
                    state_d     = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        // The wait budget restarts whenever the FSM moves on.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // State, counter and sticky-flag registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            cnt_q       <= '0;
            bus_error_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_error_q <= bus_error_d;
            illegal_q   <= illegal_d;
        end
    end

    // Datapath control decode. Strobes are masked while reset is held.
    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_src        = 2'b00;
        mem_to_reg    = 2'b00;
        instr_retired = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                // old_pc + imm lands in ALUOut as the branch/JAL target.
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            S_EXEC: begin
                unique case (opcode)
                    OP_R: begin
                        alu_src_a = 2'b01;
                        alu_op    = 2'b10;
                    end
                    OP_I: begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b10;
                        alu_op    = 2'b11;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b10;
                    end
                    OP_LUI: begin
                        alu_src_a = 2'b11;
                        alu_src_b = 2'b10;
                    end
                    OP_AUIPC: begin
                        alu_src_a = 2'b10;
                        alu_src_b = 2'b10;
                    end
                    OP_BR: begin
                        alu_src_a     = 2'b01;
                        alu_op        = 2'b01;
                        pc_write      = branch_taken;
                        pc_src        = 2'b01;
                        instr_retired = 1'b1;
                    end
                    OP_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b01;
                    end
                    OP_JALR: begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b10;
                        pc_write  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                iord      = 1'b1;
                mem_read  = (opcode == OP_LW);
                mem_write = (opcode == OP_SW);
                if (mem_ready && opcode == OP_SW) begin
                    instr_retired = 1'b1;
                end
            end
            S_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                if (opcode == OP_LW) begin
                    mem_to_reg = 2'b01;
                end else if (opcode == OP_JAL || opcode == OP_JALR) begin
                    mem_to_reg = 2'b10;
                end
            end
            default: ;
        endcase
        if (reset) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            instr_retired = 1'b0;
        end
    end

    assign state         = state_q;
    assign bus_error     = bus_error_q;
    assign illegal_instr = illegal_q;
    assign halted        = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. The driver applies one cycle of
// inputs and queues the control word expected for that cycle. A monitor
// pops and compares on the falling edge.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw, irw, iord, mrd, mwr, rw;
        logic [1:0] a, b, op, psrc, m2r;
        logic       ret, be, ill, hlt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       branch_taken = 1'b0;
    logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, pc_src, mem_to_reg;
    logic [2:0] state;
    logic       instr_retired, bus_error, illegal_instr, halted;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_write(pc_write), .ir_write(ir_write),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .mem_to_reg(mem_to_reg),
        .state(state), .instr_retired(instr_retired), .bus_error(bus_error),
        .illegal_instr(illegal_instr), .halted(halted)
    );

    always #5 clk = ~clk;

    // s = {pc_write, ir_write, iord, mem_read, mem_write, reg_write}
    // f = {bus_error, illegal_instr, halted}
    function automatic exp_t mk(input logic [2:0] st, input logic [5:0] s,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] op, input logic [1:0] ps,
                                input logic [1:0] m2r, input logic ret,
                                input logic [2:0] f);
        return {st, s, a, b, op, ps, m2r, ret, f};
    endfunction

    task automatic cyc(input string nm, input logic r, input logic [6:0] opc,
                       input logic rdy, input logic tk, input exp_t ex);
        @(posedge clk);
        #1;
        reset        = r;
        opcode       = opc;
        mem_ready    = rdy;
        branch_taken = tk;
        exp_q.push_back(ex);
        name_q.push_back(nm);
    endtask

    // Monitor: compare the DUT control word against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  ex;
            exp_t  act;
            string nm;
            ex  = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {state, pc_write, ir_write, iord, mem_read, mem_write,
                   reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
                   mem_to_reg, instr_retired, bus_error, illegal_instr, halted};
            n_tests++;
            if (act !== ex) begin
                n_fail++;
                $display("FAIL %s: actual=%b required=%b (st|pcw irw iord mrd mwr rw|a b op psrc m2r|ret be ill hlt)",
                         nm, act, ex);
            end
        end
    end

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011,
                           SW = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUI = 7'b0110111,
                           AUI = 7'b0010111, BAD = 7'b1111111;

    initial begin
        exp_t RST, F_GO, F_WT, DEC, EX_R, EX_I, EX_LS, EX_LUI, EX_AUI;
        exp_t EX_BRT, EX_BRN, EX_JAL, EX_JALR, M_LW, M_SW, M_SWD;
        exp_t WB0, WB1, WB2, TR_ILL, TR_BE;
        RST     = mk(3'd0, 6'b000000, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000);
        F_GO    = mk(3'd0, 6'b110100, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000);
        F_WT    = mk(3'd0, 6'b000100, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000);
        DEC     = mk(3'd1, 6'b000000, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000);
        EX_R    = mk(3'd2, 6'b000000, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0, 3'b000);
        EX_I    = mk(3'd2, 6'b000000, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 1'b0, 3'b000);
        EX_LS   = mk(3'd2, 6'b000000, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000);
        EX_LUI  = mk(3'd2, 6'b000000, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000);
        EX_AUI  = mk(3'd2, 6'b000000, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000);
        EX_BRT  = mk(3'd2, 6'b100000, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 1'b1, 3'b000);
        EX_BRN  = mk(3'd2, 6'b000000, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 1'b1, 3'b000);
        EX_JAL  = mk(3'd2, 6'b100000, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 3'b000);
        EX_JALR = mk(3'd2, 6'b100000, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000);
        M_LW    = mk(3'd3, 6'b001100, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000);
        M_SW    = mk(3'd3, 6'b001010, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'b000);
        M_SWD   = mk(3'd3, 6'b001010, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 3'b000);
        WB0     = mk(3'd4, 6'b000001, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 3'b000);
        WB1     = mk(3'd4, 6'b000001, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b1, 3'b000);
        WB2     = mk(3'd4, 6'b000001, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 1'b1, 3'b000);
        TR_ILL  = mk(3'd5, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'b011);
        TR_BE   = mk(3'd5, 6'b000000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'b101);

        // Reset held with mem_ready high: no strobes may leak out.
        cyc("reset",      1'b1, R, 1'b1, 1'b0, RST);
        // R-type, zero wait: 0,1,2,4.
        cyc("r_fetch",    1'b0, R, 1'b1, 1'b0, F_GO);
        cyc("r_decode",   1'b0, R, 1'b1, 1'b0, DEC);
        cyc("r_exec",     1'b0, R, 1'b1, 1'b0, EX_R);
        cyc("r_wb",       1'b0, R, 1'b1, 1'b0, WB0);
        // I-type, with a three-cycle fetch wait that ends on the last legal cycle.
        cyc("i_fwait0",   1'b0, I, 1'b0, 1'b0, F_WT);
        cyc("i_fwait1",   1'b0, I, 1'b0, 1'b0, F_WT);
        cyc("i_fwait2",   1'b0, I, 1'b0, 1'b0, F_WT);
        cyc("i_fetch_last", 1'b0, I, 1'b1, 1'b0, F_GO);
        cyc("i_decode",   1'b0, I, 1'b1, 1'b0, DEC);
        cyc("i_exec",     1'b0, I, 1'b1, 1'b0, EX_I);
        cyc("i_wb",       1'b0, I, 1'b1, 1'b0, WB0);
        // LW, three MEM wait cycles: 8 cycles total.
        cyc("lw_fetch",   1'b0, LW, 1'b1, 1'b0, F_GO);
        cyc("lw_decode",  1'b0, LW, 1'b1, 1'b0, DEC);
        cyc("lw_exec",    1'b0, LW, 1'b1, 1'b0, EX_LS);
        cyc("lw_mwait0",  1'b0, LW, 1'b0, 1'b0, M_LW);
        cyc("lw_mwait1",  1'b0, LW, 1'b0, 1'b0, M_LW);
        cyc("lw_mwait2",  1'b0, LW, 1'b0, 1'b0, M_LW);
        cyc("lw_mdone",   1'b0, LW, 1'b1, 1'b0, M_LW);
        cyc("lw_wb",      1'b0, LW, 1'b1, 1'b0, WB1);
        // Branch taken, then not taken: 3 cycles each.
        cyc("brt_fetch",  1'b0, BR, 1'b1, 1'b1, F_GO);
        cyc("brt_decode", 1'b0, BR, 1'b1, 1'b1, DEC);
        cyc("brt_exec",   1'b0, BR, 1'b1, 1'b1, EX_BRT);
        cyc("brn_fetch",  1'b0, BR, 1'b1, 1'b0, F_GO);
        cyc("brn_decode", 1'b0, BR, 1'b1, 1'b0, DEC);
        cyc("brn_exec",   1'b0, BR, 1'b1, 1'b0, EX_BRN);
        // JAL and JALR write the link value.
        cyc("jal_fetch",  1'b0, JAL, 1'b1, 1'b0, F_GO);
        cyc("jal_decode", 1'b0, JAL, 1'b1, 1'b0, DEC);
        cyc("jal_exec",   1'b0, JAL, 1'b1, 1'b0, EX_JAL);
        cyc("jal_wb",     1'b0, JAL, 1'b1, 1'b0, WB2);
        cyc("jalr_fetch", 1'b0, JALR, 1'b1, 1'b0, F_GO);
        cyc("jalr_decode",1'b0, JALR, 1'b1, 1'b0, DEC);
        cyc("jalr_exec",  1'b0, JALR, 1'b1, 1'b0, EX_JALR);
        cyc("jalr_wb",    1'b0, JALR, 1'b1, 1'b0, WB2);
        // LUI and AUIPC.
        cyc("lui_fetch",  1'b0, LUI, 1'b1, 1'b0, F_GO);
        cyc("lui_decode", 1'b0, LUI, 1'b1, 1'b0, DEC);
        cyc("lui_exec",   1'b0, LUI, 1'b1, 1'b0, EX_LUI);
        cyc("lui_wb",     1'b0, LUI, 1'b1, 1'b0, WB0);
        cyc("aui_fetch",  1'b0, AUI, 1'b1, 1'b0, F_GO);
        cyc("aui_decode", 1'b0, AUI, 1'b1, 1'b0, DEC);
        cyc("aui_exec",   1'b0, AUI, 1'b1, 1'b0, EX_AUI);
        cyc("aui_wb",     1'b0, AUI, 1'b1, 1'b0, WB0);
        // SW, zero wait: retires in MEM after 4 cycles.
        cyc("sw_fetch",   1'b0, SW, 1'b1, 1'b0, F_GO);
        cyc("sw_decode",  1'b0, SW, 1'b1, 1'b0, DEC);
        cyc("sw_exec",    1'b0, SW, 1'b1, 1'b0, EX_LS);
        cyc("sw_mdone",   1'b0, SW, 1'b1, 1'b0, M_SWD);
        // SW aborted by reset during its MEM wait, then a normal R-type.
        cyc("swa_fetch",  1'b0, SW, 1'b1, 1'b0, F_GO);
        cyc("swa_decode", 1'b0, SW, 1'b1, 1'b0, DEC);
        cyc("swa_exec",   1'b0, SW, 1'b1, 1'b0, EX_LS);
        cyc("swa_mwait0", 1'b0, SW, 1'b0, 1'b0, M_SW);
        cyc("swa_mwait1", 1'b0, SW, 1'b0, 1'b0, M_SW);
        cyc("swa_reset",  1'b1, SW, 1'b1, 1'b0, RST);
        cyc("post_fetch", 1'b0, R, 1'b1, 1'b0, F_GO);
        cyc("post_decode",1'b0, R, 1'b1, 1'b0, DEC);
        cyc("post_exec",  1'b0, R, 1'b1, 1'b0, EX_R);
        cyc("post_wb",    1'b0, R, 1'b1, 1'b0, WB0);
        // Illegal opcode traps after DECODE and stays quiet.
        cyc("ill_fetch",  1'b0, BAD, 1'b1, 1'b0, F_GO);
        cyc("ill_decode", 1'b0, BAD, 1'b1, 1'b0, DEC);
        cyc("ill_trap0",  1'b0, BAD, 1'b1, 1'b1, TR_ILL);
        cyc("ill_trap1",  1'b0, R,   1'b0, 1'b0, TR_ILL);
        cyc("ill_trap2",  1'b0, R,   1'b1, 1'b0, TR_ILL);
        cyc("ill_reset",  1'b1, R,   1'b0, 1'b0, RST);
        // Fetch watchdog: the 4th low cycle traps with bus_error.
        cyc("to_wait0",   1'b0, R, 1'b0, 1'b0, F_WT);
        cyc("to_wait1",   1'b0, R, 1'b0, 1'b0, F_WT);
        cyc("to_wait2",   1'b0, R, 1'b0, 1'b0, F_WT);
        cyc("to_wait3",   1'b0, R, 1'b0, 1'b0, F_WT);
        cyc("to_trap0",   1'b0, R, 1'b1, 1'b0, TR_BE);
        cyc("to_trap1",   1'b0, R, 1'b1, 1'b0, TR_BE);

        repeat (2) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
